regfile_param: RTL and testbench

//   Parametrised integer register file for the core: 2 combinational read ports, 1 write port, 1 debug read port.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_clear_seq.sv | 65 ++++++
 rtl/regfile_param.sv | 99 +++++++++
 tb/tb_regfile_param.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the parametrised register file and its clear sequencer.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } clr_state_t;

    localparam int unsigned X0_ADDR   = 0;
    // x0 has no storage, so a clear pass starts at the first real register
    localparam int unsigned CLR_START = 1;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks reg[1..NREGS-1] writing zero after reset or on request,
// and holds READY low until the pass completes.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic          CLK,
    input  logic          reset_n,
    input  logic          CLR_REQ,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr,
    output logic          READY
);

    localparam logic [AW-1:0] LAST_ADDR  = AW'(NREGS - 1);
    localparam logic [AW-1:0] START_ADDR = AW'(CLR_START);

    clr_state_t    state;
    clr_state_t    state_nxt;
    logic [AW-1:0] cnt;
    logic [AW-1:0] cnt_nxt;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state <= CLEAR;
            cnt   <= START_ADDR;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A request arriving while a pass is already running is deliberately ignored
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_we    = 1'b0;
        clr_addr  = cnt;
        case (state)
            CLEAR: begin
                clr_we = 1'b1;
                if (cnt == LAST_ADDR) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + AW'(1);
                end
            end
            IDLE: begin
                if (CLR_REQ) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = START_ADDR;
                end
            end
            default: begin
                state_nxt = CLEAR;
                cnt_nxt   = START_ADDR;
            end
        endcase
    end

    assign READY = (state == IDLE);

endmodule

// File: rtl/regfile_param.sv
// Integer register file: two combinational read ports with optional write bypass,
// one write port, an unbypassed debug read port, and a built-in clear sequencer.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic            CLK,
    input  logic            reset_n,
    input  logic [AW-1:0]   A1,
    input  logic [AW-1:0]   A2,
    input  logic [AW-1:0]   A3,
    input  logic            WE3,
    input  logic [XLEN-1:0] WD3,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2,
    input  logic [AW-1:0]   DBG_A,
    output logic [XLEN-1:0] DBG_RD,
    input  logic            CLR_REQ,
    output logic            READY
);

    localparam logic [AW:0] NREGS_W = (AW + 1)'(NREGS);
    localparam bit          BYP     = (BYPASS != 0);

    logic            clr_we;
    logic [AW-1:0]   clr_addr;
    logic            user_we;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    logic [XLEN-1:0] st1;
    logic [XLEN-1:0] st2;
    logic [XLEN-1:0] st_dbg;
    logic            hit1;
    logic            hit2;

    // x0 is hardwired, so storage begins at index 1
    logic [XLEN-1:0] regs [1:NREGS-1];

    function automatic logic in_range(input logic [AW-1:0] a);
        return (a != AW'(X0_ADDR)) && ({1'b0, a} < NREGS_W);
    endfunction

    regfile_clear_seq #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clear_seq (
        .CLK      (CLK),
        .reset_n  (reset_n),
        .CLR_REQ  (CLR_REQ),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .READY    (READY)
    );

    // Single storage write port; the clear pass always wins over a core write
    assign user_we = READY && WE3 && in_range(A3);
    assign wr_en   = clr_we || user_we;
    assign wr_addr = clr_we ? clr_addr : A3;
    assign wr_data = clr_we ? '0 : WD3;

    always_ff @(posedge CLK) begin
        for (int i = 1; i < NREGS; i++) begin
            if (wr_en && (wr_addr == AW'(i))) begin
                regs[i] <= wr_data;
            end
        end
    end

    // Address 0 and out-of-range addresses never match, so they read as zero
    always_comb begin
        st1    = '0;
        st2    = '0;
        st_dbg = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (A1 == AW'(i)) begin
                st1 = regs[i];
            end
            if (A2 == AW'(i)) begin
                st2 = regs[i];
            end
            if (DBG_A == AW'(i)) begin
                st_dbg = regs[i];
            end
        end
    end

    assign hit1 = BYP && WE3 && (A3 == A1);
    assign hit2 = BYP && WE3 && (A3 == A2);

    assign RD1    = (!READY || !in_range(A1)) ? '0 : (hit1 ? WD3 : st1);
    assign RD2    = (!READY || !in_range(A2)) ? '0 : (hit2 ? WD3 : st2);
    assign DBG_RD = st_dbg;

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: default build, a no-bypass build and an 18-register build
// share one stimulus stream and are checked against hand-computed values.
module tb_regfile_param;

    logic        CLK;
    logic        reset_n;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [4:0]  A3;
    logic        WE3;
    logic [31:0] WD3;
    logic [4:0]  DBG_A;
    logic        CLR_REQ;

    logic [31:0] rd1, rd2, dbg;
    logic [31:0] rd1_nb, rd2_nb, dbg_nb;
    logic [31:0] rd1_18, rd2_18, dbg_18;
    logic        ready, ready_nb, ready_18;

    int n_vec  = 0;
    int n_fail = 0;
    int nm, nn, n18;

    typedef struct {
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  a3;
        logic        we;
        logic [31:0] wd;
        logic [4:0]  dbg_a;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic [31:0] e_dbg;
        logic [31:0] e_nb1;
        logic [31:0] e_nb2;
    } vec_t;

    vec_t vecs [9];

    regfile_param #(.XLEN(32), .NREGS(32), .AW(5), .BYPASS(1)) u_dut (
        .CLK(CLK), .reset_n(reset_n), .A1(A1), .A2(A2), .A3(A3), .WE3(WE3), .WD3(WD3),
        .RD1(rd1), .RD2(rd2), .DBG_A(DBG_A), .DBG_RD(dbg), .CLR_REQ(CLR_REQ), .READY(ready)
    );

    regfile_param #(.XLEN(32), .NREGS(32), .AW(5), .BYPASS(0)) u_nb (
        .CLK(CLK), .reset_n(reset_n), .A1(A1), .A2(A2), .A3(A3), .WE3(WE3), .WD3(WD3),
        .RD1(rd1_nb), .RD2(rd2_nb), .DBG_A(DBG_A), .DBG_RD(dbg_nb), .CLR_REQ(CLR_REQ), .READY(ready_nb)
    );

    regfile_param #(.XLEN(32), .NREGS(18), .AW(5), .BYPASS(1)) u_18 (
        .CLK(CLK), .reset_n(reset_n), .A1(A1), .A2(A2), .A3(A3), .WE3(WE3), .WD3(WD3),
        .RD1(rd1_18), .RD2(rd2_18), .DBG_A(DBG_A), .DBG_RD(dbg_18), .CLR_REQ(CLR_REQ), .READY(ready_18)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    // Counts rising edges until each build reports READY; 0 means it never rose within the bound
    task automatic count_ready(output int c_main, output int c_nb, output int c_18);
        c_main = 0;
        c_nb   = 0;
        c_18   = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge CLK);
            #1;
            WE3     = 1'b0;
            CLR_REQ = 1'b0;
            if (ready === 1'b1 && c_main == 0) c_main = e;
            if (ready_nb === 1'b1 && c_nb == 0) c_nb = e;
            if (ready_18 === 1'b1 && c_18 == 0) c_18 = e;
        end
    endtask

    initial begin
        vecs[0] = '{5'd7,  5'd0,  5'd7,  1'b1, 32'hDEADBEEF, 5'd7,  32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        32'h0};
        vecs[1] = '{5'd7,  5'd7,  5'd7,  1'b0, 32'h0,        5'd7,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2] = '{5'd0,  5'd0,  5'd0,  1'b1, 32'h12345678, 5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0};
        vecs[3] = '{5'd0,  5'd7,  5'd0,  1'b0, 32'h0,        5'd0,  32'h0,        32'hDEADBEEF, 32'h0,        32'h0,        32'hDEADBEEF};
        vecs[4] = '{5'd3,  5'd5,  5'd3,  1'b1, 32'hA5A5A5A5, 5'd3,  32'hA5A5A5A5, 32'h0,        32'h0,        32'h0,        32'h0};
        vecs[5] = '{5'd4,  5'd4,  5'd4,  1'b1, 32'h11112222, 5'd3,  32'h11112222, 32'h11112222, 32'hA5A5A5A5, 32'h0,        32'h0};
        vecs[6] = '{5'd31, 5'd3,  5'd31, 1'b1, 32'hCAFEF00D, 5'd4,  32'hCAFEF00D, 32'hA5A5A5A5, 32'h11112222, 32'h0,        32'hA5A5A5A5};
        vecs[7] = '{5'd31, 5'd31, 5'd31, 1'b1, 32'h00000001, 5'd31, 32'h00000001, 32'h00000001, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D};
        vecs[8] = '{5'd31, 5'd4,  5'd31, 1'b0, 32'h0,        5'd31, 32'h00000001, 32'h11112222, 32'h00000001, 32'h00000001, 32'h11112222};

        reset_n = 1'b0;
        A1 = 5'd5; A2 = '0; A3 = '0; WE3 = 1'b0; WD3 = '0; DBG_A = 5'd31; CLR_REQ = 1'b0;

        // Power-up clear
        repeat (2) @(negedge CLK);
        #2;
        check("reset ready", 32'(ready), 32'd0);
        check("reset ready_18", 32'(ready_18), 32'd0);
        check("reset rd1", rd1, 32'h0);
        @(negedge CLK);
        reset_n = 1'b1;
        #2;
        check("clearing rd1", rd1, 32'h0);
        count_ready(nm, nn, n18);
        check("init ready edges", 32'(nm), 32'd31);
        check("init ready edges nb", 32'(nn), 32'd31);
        check("init ready edges 18", 32'(n18), 32'd17);
        @(negedge CLK);
        A1 = 5'd5; DBG_A = 5'd31;
        #2;
        check("post-clear rd1 x5", rd1, 32'h0);
        check("post-clear dbg x31", dbg, 32'h0);
        check("post-clear rd1_18 x5", rd1_18, 32'h0);

        // Table: bypass, x0 writes, debug port, both ports on one address
        for (int i = 0; i < 9; i++) begin
            @(negedge CLK);
            A1 = vecs[i].a1; A2 = vecs[i].a2; A3 = vecs[i].a3;
            WE3 = vecs[i].we; WD3 = vecs[i].wd; DBG_A = vecs[i].dbg_a;
            #2;
            check($sformatf("v%0d rd1", i), rd1, vecs[i].e_rd1);
            check($sformatf("v%0d rd2", i), rd2, vecs[i].e_rd2);
            check($sformatf("v%0d dbg", i), dbg, vecs[i].e_dbg);
            check($sformatf("v%0d rd1_nb", i), rd1_nb, vecs[i].e_nb1);
            check($sformatf("v%0d rd2_nb", i), rd2_nb, vecs[i].e_nb2);
        end

        // Out-of-range write on the 18-register build, dual-port bypass there
        @(negedge CLK);
        WE3 = 1'b1; A3 = 5'd20; WD3 = 32'h20202020; A1 = 5'd20; A2 = 5'd4; DBG_A = 5'd20;
        #2;
        check("n18 rd1 x20 wr", rd1_18, 32'h0);
        check("main rd1 x20 bypass", rd1, 32'h20202020);
        @(negedge CLK);
        WE3 = 1'b0;
        #2;
        check("n18 rd1 x20 after", rd1_18, 32'h0);
        check("n18 dbg x20 after", dbg_18, 32'h0);
        check("main dbg x20 after", dbg, 32'h20202020);
        check("n18 rd2 x4", rd2_18, 32'h11112222);
        @(negedge CLK);
        WE3 = 1'b1; A1 = 5'd4; A2 = 5'd4; A3 = 5'd4; WD3 = 32'h0BADF00D;
        #2;
        check("n18 rd1 x4 bypass", rd1_18, 32'h0BADF00D);
        check("n18 rd2 x4 bypass", rd2_18, 32'h0BADF00D);
        @(negedge CLK);
        WE3 = 1'b0;
        #2;
        check("n18 rd1 x4 stored", rd1_18, 32'h0BADF00D);

        // Clear request together with a write; a write during the clear is dropped
        @(negedge CLK);
        WE3 = 1'b1; A3 = 5'd9; WD3 = 32'h00000099; CLR_REQ = 1'b1; A1 = 5'd3; A2 = 5'd7; DBG_A = 5'd9;
        #2;
        check("pre-clear rd1 x3", rd1, 32'hA5A5A5A5);
        @(posedge CLK);
        #1;
        CLR_REQ = 1'b0;
        WE3 = 1'b1; A3 = 5'd3; WD3 = 32'h00000001;
        #1;
        check("clr ready low", 32'(ready), 32'd0);
        check("clr rd1 zero", rd1, 32'h0);
        check("clr dbg x9 written", dbg, 32'h00000099);
        count_ready(nm, nn, n18);
        check("clr ready edges", 32'(nm), 32'd31);
        check("clr ready edges 18", 32'(n18), 32'd17);
        @(negedge CLK);
        A1 = 5'd3; A2 = 5'd7; DBG_A = 5'd9;
        #2;
        check("after clr rd1 x3", rd1, 32'h0);
        check("after clr rd2 x7", rd2, 32'h0);
        check("after clr dbg x9", dbg, 32'h0);
        check("after clr rd1_nb x3", rd1_nb, 32'h0);

        // Reset mid-clear restarts the whole pass
        @(negedge CLK);
        CLR_REQ = 1'b1;
        @(posedge CLK);
        #1;
        CLR_REQ = 1'b0;
        repeat (9) @(posedge CLK);
        #1;
        reset_n = 1'b0;
        repeat (2) @(negedge CLK);
        #2;
        check("midclr reset ready", 32'(ready), 32'd0);
        @(negedge CLK);
        reset_n = 1'b1;
        count_ready(nm, nn, n18);
        check("restart ready edges", 32'(nm), 32'd31);
        check("restart ready edges 18", 32'(n18), 32'd17);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
